// File: rtl/mod_pkg.sv
// Shared encodings and defaults for the modulator burst sequencer.
// Used by mod_tx_sequencer and its symbol tick generator.
package mod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int NB_COUNT_DEF = 3;
  localparam int NB_LEN_DEF   = 10;
  localparam int N_FLUSH_DEF  = 6;

endpackage

// File: rtl/mod_tx_sequencer_symbol_tick_gen.sv
// Clear-able clock divider producing the 1-cycle symbol strobe.
// Counts only while running; held at zero otherwise.
module symbol_tick_gen
  import mod_pkg::*;
#(
  parameter int NB_COUNT = NB_COUNT_DEF
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_run,
  input  logic i_clear,
  output logic o_tick
);

  localparam logic [NB_COUNT-1:0] CNT_ONE = NB_COUNT'(1);

  logic [NB_COUNT-1:0] cnt_q;
  logic [NB_COUNT-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (i_run && !i_clear) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = i_run && (&cnt_q);

endmodule

// File: rtl/mod_tx_sequencer.sv
// Burst controller for the PRBS -> FIR chain: symbol strobe plus
// run / flush / done sequencing of the block enables.
module mod_tx_sequencer
  import mod_pkg::*;
#(
  parameter int NB_COUNT = NB_COUNT_DEF,
  parameter int NB_LEN   = NB_LEN_DEF,
  parameter int N_FLUSH  = N_FLUSH_DEF
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_continuous,
  input  logic [NB_LEN-1:0] i_burst_len,
  output logic              o_valid,
  output logic              o_prbs_enable,
  output logic              o_fir_enable,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_state,
  output logic [NB_LEN-1:0] o_sym_count
);

  localparam int NB_FL = $clog2(N_FLUSH + 1);
  localparam logic [NB_LEN-1:0] LEN_ONE = NB_LEN'(1);
  localparam logic [NB_FL-1:0]  FL_ONE  = NB_FL'(1);
  localparam logic [NB_FL-1:0]  FL_LAST = NB_FL'(N_FLUSH - 1);

  state_t             state_q, state_d;
  logic [NB_LEN-1:0]  sym_q, sym_d;
  logic [NB_LEN-1:0]  len_q, len_d;
  logic               cont_q, cont_d;
  logic [NB_FL-1:0]   fl_q, fl_d;
  logic               run;
  logic               clear;
  logic               tick;

  assign run   = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign clear = (state_q == ST_RUN) && i_stop;

  symbol_tick_gen #(
    .NB_COUNT (NB_COUNT)
  ) u_tick (
    .clock   (clock),
    .i_reset (i_reset),
    .i_run   (run),
    .i_clear (clear),
    .o_tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    len_d   = len_q;
    cont_d  = cont_q;
    fl_d    = fl_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start && (i_continuous || (i_burst_len != '0))) begin
          state_d = ST_RUN;
          len_d   = i_burst_len;
          cont_d  = i_continuous;
          sym_d   = '0;
        end
      end
      ST_RUN: begin
        if (tick) begin
          sym_d = sym_q + LEN_ONE;
        end
        // a stop on the final strobe still counts that strobe
        if (i_stop ||
            (tick && !cont_q && (sym_q == len_q - LEN_ONE))) begin
          state_d = ST_FLUSH;
          fl_d    = '0;
        end
      end
      ST_FLUSH: begin
        if (tick) begin
          if (fl_q == FL_LAST) begin
            state_d = ST_DONE;
          end else begin
            fl_d = fl_q + FL_ONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      sym_q   <= '0;
      len_q   <= '0;
      cont_q  <= 1'b0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      len_q   <= len_d;
      cont_q  <= cont_d;
      fl_q    <= fl_d;
    end
  end

  assign o_valid       = tick;
  assign o_state       = state_q;
  assign o_prbs_enable = (state_q == ST_RUN);
  assign o_fir_enable  = run;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = (state_q == ST_DONE);
  assign o_sym_count   = sym_q;

endmodule
